// File: rtl/writeback_arbiter_pkg.sv
// Shared types and defaults for the execute-stage write-back arbiter.
// inst_decoded_t is the record carried from the ALU and multiplier paths to the register file.
package writeback_arbiter_pkg;

    localparam int DATA_W            = 32;
    localparam int REG_W             = 5;
    localparam int WB_MUL_FIFO_DEPTH = 2;
    localparam int WB_STARVE_LIMIT   = 4;

    typedef struct packed {
        logic              valid;
        logic              reg_data_ready;
        logic [REG_W-1:0]  dst_reg;
        logic [DATA_W-1:0] reg_data;
    } inst_decoded_t;

    function automatic logic is_candidate(input inst_decoded_t rec);
        return rec.valid & rec.reg_data_ready;
    endfunction

endpackage

// File: rtl/writeback_arbiter_fifo.sv
// Single-clock result buffer for multiplier write-backs; full/empty come from the count.
// Storage is not reset; only pointers and count are.
module wb_result_fifo
    import writeback_arbiter_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  inst_decoded_t push_data,
    input  logic          pop,
    output inst_decoded_t head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    inst_decoded_t mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A pop frees the head slot at the same edge, so push-while-full is safe when popping.
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU/mem results and buffered multiplier results onto the single register-file write port.
// ALU normally wins; a saturating starvation counter bounds how long the multiplier head can wait.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter  int MUL_FIFO_DEPTH = WB_MUL_FIFO_DEPTH,
    parameter  int STARVE_LIMIT   = WB_STARVE_LIMIT,
    localparam int CW             = $clog2(MUL_FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  inst_decoded_t inst_alu_in,
    input  inst_decoded_t inst_mul_in,
    output logic          stall_mul_out,
    output logic          stall_alu_out,
    output inst_decoded_t inst_wb_out,
    output logic [CW-1:0] mul_fifo_count
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
        return (v == SW'(STARVE_LIMIT)) ? v : v + 1'b1;
    endfunction

    logic          alu_cand_p0;
    logic          mul_push_p0;
    logic          head_wins_p0;
    logic          starve_hit_p0;
    logic          win_vld_p0;
    inst_decoded_t win_p0;
    inst_decoded_t head_p0;
    logic          fifo_full;
    logic          fifo_empty;
    logic [SW-1:0] starve_cnt;

    logic          wb_vld_p1;
    logic          wb_rdy_p1;
    inst_decoded_t wb_rec_p1;

    // Stage p0: candidate qualification and arbitration
    assign alu_cand_p0   = is_candidate(inst_alu_in);
    assign stall_mul_out = fifo_full;
    assign mul_push_p0   = is_candidate(inst_mul_in) & ~stall_mul_out;
    assign starve_hit_p0 = (starve_cnt == SW'(STARVE_LIMIT));
    assign head_wins_p0  = ~fifo_empty & (~alu_cand_p0 | starve_hit_p0);
    assign stall_alu_out = alu_cand_p0 & head_wins_p0;
    assign win_vld_p0    = alu_cand_p0 | head_wins_p0;
    assign win_p0        = head_wins_p0 ? head_p0 : inst_alu_in;

    wb_result_fifo #(
        .DEPTH(MUL_FIFO_DEPTH)
    ) u_mul_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (mul_push_p0),
        .push_data(inst_mul_in),
        .pop      (head_wins_p0),
        .head     (head_p0),
        .count    (mul_fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
            wb_vld_p1  <= 1'b0;
            wb_rdy_p1  <= 1'b0;
        end else begin
            if (head_wins_p0 || fifo_empty) begin
                starve_cnt <= '0;
            end else if (alu_cand_p0) begin
                starve_cnt <= sat_inc(starve_cnt);
            end
            wb_vld_p1 <= win_vld_p0;
            wb_rdy_p1 <= win_vld_p0 & (win_p0.dst_reg != '0);
        end
    end

    // Stage p1: registered write-back record; payload holds when nothing wins
    always_ff @(posedge clk) begin
        if (win_vld_p0) begin
            wb_rec_p1 <= win_p0;
        end
    end

    always_comb begin
        inst_wb_out                = wb_rec_p1;
        inst_wb_out.valid          = wb_vld_p1;
        inst_wb_out.reg_data_ready = wb_rdy_p1;
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter: queued ALU/MUL sources honour the stalls,
// write-backs are collected per cycle and compared against expected order and timing.
`timescale 1ns/1ps
module tb_writeback_arbiter;
    import writeback_arbiter_pkg::*;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    inst_decoded_t alu_in;
    inst_decoded_t mul_in;
    inst_decoded_t wb_out;
    logic          stall_mul;
    logic          stall_alu;
    logic [CW-1:0] cnt;

    writeback_arbiter #(
        .MUL_FIFO_DEPTH(DEPTH),
        .STARVE_LIMIT  (LIMIT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .inst_alu_in   (alu_in),
        .inst_mul_in   (mul_in),
        .stall_mul_out (stall_mul),
        .stall_alu_out (stall_alu),
        .inst_wb_out   (wb_out),
        .mul_fifo_count(cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        inst_decoded_t rec;
        int            cyc;
    } obs_t;

    inst_decoded_t alu_src[$];
    inst_decoded_t mul_src[$];
    inst_decoded_t exp_q[$];
    obs_t          obs_q[$];
    int            cyc    = 0;
    int            checks = 0;
    int            errors = 0;
    bit            hist_alu [0:1023];
    bit            hist_mul [0:1023];
    int            hist_cnt [0:1023];

    function automatic inst_decoded_t mk(input logic [4:0] d, input logic [31:0] v);
        inst_decoded_t r;
        r.valid          = 1'b1;
        r.reg_data_ready = 1'b1;
        r.dst_reg        = d;
        r.reg_data       = v;
        return r;
    endfunction

    // Expected register-file view: x0 is consumed but never written.
    function automatic inst_decoded_t wb_of(input inst_decoded_t r);
        inst_decoded_t e;
        e                = r;
        e.reg_data_ready = (r.dst_reg != 5'd0);
        return e;
    endfunction

    task automatic refresh();
        if (alu_src.size() != 0) alu_in = alu_src[0];
        else                     alu_in = '0;
        if (mul_src.size() != 0) mul_in = mul_src[0];
        else                     mul_in = '0;
    endtask

    task automatic clear_all();
        alu_src.delete();
        mul_src.delete();
        exp_q.delete();
        obs_q.delete();
        refresh();
    endtask

    task automatic tick();
        bit   alu_taken;
        bit   mul_taken;
        obs_t o;
        @(negedge clk);
        alu_taken = alu_in.valid && !stall_alu;
        mul_taken = mul_in.valid && !stall_mul;
        if (cyc < 1024) begin
            hist_alu[cyc] = stall_alu;
            hist_mul[cyc] = stall_mul;
            hist_cnt[cyc] = int'(cnt);
        end
        @(posedge clk);
        #1;
        if (wb_out.valid) begin
            o.rec = wb_out;
            o.cyc = cyc;
            obs_q.push_back(o);
        end
        if (alu_taken) void'(alu_src.pop_front());
        if (mul_taken) void'(mul_src.pop_front());
        cyc++;
        refresh();
    endtask

    task automatic test_reset();
        alu_in = '0;
        mul_in = '0;
        #1;
        checks++;
        if (cnt !== '0 || wb_out.valid !== 1'b0 || wb_out.reg_data_ready !== 1'b0) begin
            errors++;
            $display("FAIL por_state cnt=%0d valid=%b rdy=%b want 0/0/0", cnt, wb_out.valid, wb_out.reg_data_ready);
        end
        checks++;
        if (stall_mul !== 1'b0 || stall_alu !== 1'b0) begin
            errors++;
            $display("FAIL por_stalls mul=%b alu=%b want 0/0", stall_mul, stall_alu);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        clear_all();
        for (int i = 0; i < 6; i++) alu_src.push_back(mk(5'(20 + i), 32'(32'h500 + i)));
        for (int i = 0; i < 3; i++) mul_src.push_back(mk(5'(2 + i), 32'(32'h600 + i)));
        refresh();
        repeat (2) tick();
        checks++;
        if (cnt !== CW'(2)) begin
            errors++;
            $display("FAIL rst_pre_fill cnt=%0d want 2", cnt);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (cnt !== '0 || wb_out.valid !== 1'b0 || wb_out.reg_data_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_async cnt=%0d valid=%b rdy=%b want 0/0/0", cnt, wb_out.valid, wb_out.reg_data_ready);
        end
        checks++;
        if (stall_mul !== 1'b0 || stall_alu !== 1'b0) begin
            errors++;
            $display("FAIL rst_async_stalls mul=%b alu=%b want 0/0", stall_mul, stall_alu);
        end
        clear_all();
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (4) tick();
        checks++;
        if (obs_q.size() != 0 || cnt !== '0) begin
            errors++;
            $display("FAIL rst_dropped writes=%0d cnt=%0d want 0/0", obs_q.size(), cnt);
        end
    endtask

    task automatic test_alu_only();
        int c0;
        clear_all();
        c0 = cyc;
        alu_src.push_back(mk(5'd5, 32'h11));
        exp_q.push_back(wb_of(mk(5'd5, 32'h11)));
        refresh();
        tick();
        checks++;
        if (obs_q.size() != 1 || obs_q[0].rec !== exp_q[0] || obs_q[0].cyc != c0) begin
            errors++;
            $display("FAIL alu_only writes=%0d rec=%h want %h at cyc %0d", obs_q.size(),
                     (obs_q.size() != 0) ? obs_q[0].rec : '0, exp_q[0], c0);
        end
        checks++;
        if (cnt !== '0 || hist_cnt[c0] != 0) begin
            errors++;
            $display("FAIL alu_only_fifo cnt=%0d want 0", cnt);
        end
        tick();
        checks++;
        if (wb_out.valid !== 1'b0 || wb_out.reg_data_ready !== 1'b0 || wb_out.dst_reg !== 5'd5) begin
            errors++;
            $display("FAIL alu_idle_hold valid=%b rdy=%b dst=%0d want 0/0/5", wb_out.valid, wb_out.reg_data_ready, wb_out.dst_reg);
        end
    endtask

    task automatic test_mul_only();
        int c0;
        int a;
        int b;
        int hi;
        a  = 3;
        b  = 7;
        hi = 0;
        clear_all();
        c0 = cyc;
        mul_src.push_back(mk(5'd6, 32'(a * b)));
        exp_q.push_back(wb_of(mk(5'd6, 32'd21)));
        refresh();
        repeat (4) tick();
        checks++;
        if (obs_q.size() != 1 || obs_q[0].rec !== exp_q[0] || obs_q[0].cyc != c0 + 1) begin
            errors++;
            $display("FAIL mul_only writes=%0d rec=%h cyc=%0d want %h cyc %0d", obs_q.size(),
                     (obs_q.size() != 0) ? obs_q[0].rec : '0, (obs_q.size() != 0) ? obs_q[0].cyc : -1, exp_q[0], c0 + 1);
        end
        for (int i = c0; i < c0 + 4; i++) if (hist_mul[i]) hi++;
        checks++;
        if (hi != 0) begin
            errors++;
            $display("FAIL mul_only_stall high_cycles=%0d want 0", hi);
        end
    endtask

    task automatic test_collision();
        int c0;
        clear_all();
        c0 = cyc;
        alu_src.push_back(mk(5'd1, 32'hA1));
        mul_src.push_back(mk(5'd2, 32'hB2));
        exp_q.push_back(wb_of(mk(5'd1, 32'hA1)));
        exp_q.push_back(wb_of(mk(5'd2, 32'hB2)));
        refresh();
        repeat (4) tick();
        checks++;
        if (obs_q.size() != 2) begin
            errors++;
            $display("FAIL coll_writes got %0d want 2", obs_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs_q.size() || obs_q[i].rec !== exp_q[i] || obs_q[i].cyc != c0 + i) begin
                errors++;
                $display("FAIL coll_order idx=%0d rec=%h cyc=%0d want %h cyc %0d", i,
                         (i < obs_q.size()) ? obs_q[i].rec : '0, (i < obs_q.size()) ? obs_q[i].cyc : -1, exp_q[i], c0 + i);
            end
        end
        checks++;
        if (cnt !== '0) begin
            errors++;
            $display("FAIL coll_drain cnt=%0d want 0", cnt);
        end
    endtask

    task automatic test_starvation();
        int c0;
        int pulses;
        pulses = 0;
        clear_all();
        c0 = cyc;
        for (int i = 0; i < 10; i++) alu_src.push_back(mk(5'(10 + i), 32'(32'h100 + i)));
        mul_src.push_back(mk(5'd7, 32'h77));
        for (int i = 0; i < 5; i++) exp_q.push_back(wb_of(mk(5'(10 + i), 32'(32'h100 + i))));
        exp_q.push_back(wb_of(mk(5'd7, 32'h77)));
        for (int i = 5; i < 10; i++) exp_q.push_back(wb_of(mk(5'(10 + i), 32'(32'h100 + i))));
        refresh();
        repeat (16) tick();
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs_q.size() || obs_q[i].rec !== exp_q[i]) begin
                errors++;
                $display("FAIL starve_order idx=%0d rec=%h want %h", i, (i < obs_q.size()) ? obs_q[i].rec : '0, exp_q[i]);
            end
        end
        for (int i = c0; i < c0 + 16; i++) if (hist_alu[i]) pulses++;
        checks++;
        if (pulses != 1 || !hist_alu[c0 + LIMIT + 1]) begin
            errors++;
            $display("FAIL starve_pulse pulses=%0d at_5th=%b want 1/1", pulses, hist_alu[c0 + LIMIT + 1]);
        end
        checks++;
        if (obs_q.size() < 6 || obs_q[5].cyc != c0 + LIMIT + 1) begin
            errors++;
            $display("FAIL starve_mul_cyc got %0d want %0d", (obs_q.size() >= 6) ? obs_q[5].cyc : -1, c0 + LIMIT + 1);
        end
    endtask

    task automatic test_full_fifo();
        int            c0;
        int            pulses;
        int            maxc;
        int            ai;
        inst_decoded_t m [3];
        pulses = 0;
        maxc   = 0;
        ai     = 0;
        clear_all();
        c0   = cyc;
        m[0] = mk(5'd3, 32'h300);
        m[1] = mk(5'd0, 32'h3A0);
        m[2] = mk(5'd4, 32'h400);
        for (int i = 0; i < 20; i++) alu_src.push_back(mk(5'(8 + i), 32'(32'h800 + i)));
        for (int k = 0; k < 3; k++) mul_src.push_back(m[k]);
        // ALU gets four slots between consecutive MUL drains, five before the first.
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < ((k == 0) ? 5 : 4); j++) begin
                exp_q.push_back(wb_of(mk(5'(8 + ai), 32'(32'h800 + ai))));
                ai++;
            end
            exp_q.push_back(wb_of(m[k]));
        end
        while (ai < 20) begin
            exp_q.push_back(wb_of(mk(5'(8 + ai), 32'(32'h800 + ai))));
            ai++;
        end
        refresh();
        repeat (26) tick();
        checks++;
        if (obs_q.size() != 23) begin
            errors++;
            $display("FAIL full_writes got %0d want 23", obs_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs_q.size() || obs_q[i].rec !== exp_q[i]) begin
                errors++;
                $display("FAIL full_order idx=%0d rec=%h want %h", i, (i < obs_q.size()) ? obs_q[i].rec : '0, exp_q[i]);
            end
        end
        checks++;
        if (hist_mul[c0 + 1] !== 1'b0 || hist_mul[c0 + 2] !== 1'b1 || hist_mul[c0 + 5] !== 1'b1 || hist_mul[c0 + 6] !== 1'b0) begin
            errors++;
            $display("FAIL full_stall_mul c1=%b c2=%b c5=%b c6=%b want 0/1/1/0",
                     hist_mul[c0 + 1], hist_mul[c0 + 2], hist_mul[c0 + 5], hist_mul[c0 + 6]);
        end
        for (int i = c0; i < c0 + 26; i++) begin
            if (hist_alu[i]) pulses++;
            if (hist_cnt[i] > maxc) maxc = hist_cnt[i];
        end
        checks++;
        if (pulses != 3 || !hist_alu[c0 + 5] || !hist_alu[c0 + 10] || !hist_alu[c0 + 15]) begin
            errors++;
            $display("FAIL full_stall_alu pulses=%0d c5=%b c10=%b c15=%b want 3/1/1/1",
                     pulses, hist_alu[c0 + 5], hist_alu[c0 + 10], hist_alu[c0 + 15]);
        end
        checks++;
        if (maxc != DEPTH || cnt !== '0 || mul_src.size() != 0) begin
            errors++;
            $display("FAIL full_occupancy max=%0d end_cnt=%0d pending=%0d want 2/0/0", maxc, cnt, mul_src.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu_only();
        test_mul_only();
        test_collision();
        test_starvation();
        test_full_fifo();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
